// File: rtl/uart_frame_arbiter.sv
// Two-requester frame arbiter feeding a byte-wide UART transmitter.
// Each frame is SYNC_BYTE, an ID byte naming the granted channel, 1..MAX_PAYLOAD
// payload bytes and an XOR checksum over the ID and payload bytes.
module uart_frame_arbiter #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s0_valid,
  input  logic [7:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [7:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       uart_transmit,
  output logic [7:0] uart_tx_byte,
  input  logic       uart_is_transmitting,
  output logic       busy,
  output logic       grant,
  output logic       frame_done,
  output logic       overflow
);

  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_ID, ST_PAYLOAD, ST_CHK} state_e;
  typedef enum logic [1:0] {PH_LOAD, PH_PULSE, PH_WAIT_BUSY, PH_WAIT_DONE} phase_e;

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  logic [7:0] chk_q, chk_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tx_byte_d;
  logic       grant_d, busy_d, frame_done_d, overflow_d;
  logic       rr_q, rr_d;        // channel that wins the next tie
  logic       close_q, close_d;  // current payload byte ends the payload
  logic       ovf_q, ovf_d;      // payload was closed by the length limit
  logic       g_valid, g_last;
  logic [7:0] g_data;
  logic [8:0] cnt_inc;
  logic       at_max, accept;

  assign g_valid  = grant ? s1_valid : s0_valid;
  assign g_data   = grant ? s1_data  : s0_data;
  assign g_last   = grant ? s1_last  : s0_last;
  assign cnt_inc  = {1'b0, cnt_q} + 9'd1;
  assign at_max   = (cnt_inc == 9'(MAX_PAYLOAD));
  assign accept   = (state_q == ST_PAYLOAD) && (phase_q == PH_LOAD) &&
                    !uart_is_transmitting && g_valid;
  assign s0_ready = accept && !grant;
  assign s1_ready = accept && grant;
  assign uart_transmit = (phase_q == PH_PULSE);

  // Next-state logic: frame-level state plus the per-byte load/pulse/wait phase.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    chk_d        = chk_q;
    cnt_d        = cnt_q;
    tx_byte_d    = uart_tx_byte;
    grant_d      = grant;
    busy_d       = busy;
    frame_done_d = 1'b0;
    overflow_d   = 1'b0;
    rr_d         = rr_q;
    close_d      = close_q;
    ovf_d        = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (!uart_is_transmitting && (s0_valid || s1_valid)) begin
          grant_d = (s0_valid && s1_valid) ? rr_q : s1_valid;
          busy_d  = 1'b1;
          state_d = ST_SYNC;
          phase_d = PH_LOAD;
          cnt_d   = '0;
          chk_d   = '0;
          close_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        case (phase_q)
          PH_LOAD: begin
            // Loading only while the UART is idle keeps uart_tx_byte stable
            // for the whole time the transmitter is shifting it out.
            if (!uart_is_transmitting) begin
              case (state_q)
                ST_SYNC: begin
                  tx_byte_d = SYNC_BYTE;
                  phase_d   = PH_PULSE;
                end
                ST_ID: begin
                  tx_byte_d = {7'b0, grant};
                  chk_d     = chk_q ^ {7'b0, grant};
                  phase_d   = PH_PULSE;
                end
                ST_PAYLOAD: begin
                  if (g_valid) begin
                    tx_byte_d = g_data;
                    chk_d     = chk_q ^ g_data;
                    cnt_d     = cnt_inc[7:0];
                    close_d   = g_last || at_max;
                    ovf_d     = !g_last && at_max;
                    phase_d   = PH_PULSE;
                  end
                end
                ST_CHK: begin
                  tx_byte_d = chk_q;
                  phase_d   = PH_PULSE;
                end
                default: ;
              endcase
            end
          end
          PH_PULSE: phase_d = PH_WAIT_BUSY;
          PH_WAIT_BUSY: begin
            if (uart_is_transmitting) phase_d = PH_WAIT_DONE;
          end
          PH_WAIT_DONE: begin
            if (!uart_is_transmitting) begin
              phase_d = PH_LOAD;
              case (state_q)
                ST_SYNC:    state_d = ST_ID;
                ST_ID:      state_d = ST_PAYLOAD;
                ST_PAYLOAD: state_d = close_q ? ST_CHK : ST_PAYLOAD;
                ST_CHK: begin
                  state_d      = ST_IDLE;
                  busy_d       = 1'b0;
                  frame_done_d = 1'b1;
                  overflow_d   = ovf_q;
                  rr_d         = !grant;
                end
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_LOAD;
      chk_q        <= '0;
      cnt_q        <= '0;
      uart_tx_byte <= '0;
      grant        <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
      rr_q         <= 1'b0;
      close_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      chk_q        <= chk_d;
      cnt_q        <= cnt_d;
      uart_tx_byte <= tx_byte_d;
      grant        <= grant_d;
      busy         <= busy_d;
      frame_done   <= frame_done_d;
      overflow     <= overflow_d;
      rr_q         <= rr_d;
      close_q      <= close_d;
      ovf_q        <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Bench for uart_frame_arbiter: queue-driven requesters, a UART busy model,
// and a frame-level reference model of the expected byte stream.
module tb_uart_frame_arbiter;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         MAXP = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s0_valid, s0_last, s0_ready, s1_valid, s1_last, s1_ready;
  logic [7:0] s0_data, s1_data, uart_tx_byte;
  logic       uart_transmit, busy, grant, frame_done, overflow;
  logic       ub = 1'b0;
  int         ucnt = 0;
  int         bt = 4;
  int         epoch = 0;

  uart_frame_arbiter #(.SYNC_BYTE(SYNC), .MAX_PAYLOAD(MAXP)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
    .uart_is_transmitting(ub), .busy(busy), .grant(grant),
    .frame_done(frame_done), .overflow(overflow));

  // UART model: busy for bt cycles after each start pulse
  always @(posedge clk) begin
    if (uart_transmit && !ub) begin
      ub   <= 1'b1;
      ucnt <= bt;
    end else if (ub) begin
      if (ucnt <= 1) ub <= 1'b0;
      ucnt <= ucnt - 1;
    end
  end

  // Requester queues ({last, data}) and model copies
  logic [8:0] q0[$], q1[$], m0[$], m1[$];
  logic [8:0] exp_q[$], log_q[$];
  int  exp_done, exp_ovf;
  bit  rr_m;
  int  errors = 0, checks = 0;

  // Requester driver: pops a byte after a sampled handshake, presents the next
  initial begin
    bit h0, h1;
    s0_valid = 0; s1_valid = 0; s0_data = 0; s1_data = 0; s0_last = 0; s1_last = 0;
    forever begin
      @(negedge clk);
      h0 = s0_valid && s0_ready;
      h1 = s1_valid && s1_ready;
      @(posedge clk);
      #1;
      if (h0 && q0.size() > 0) void'(q0.pop_front());
      if (h1 && q1.size() > 0) void'(q1.pop_front());
      s0_valid = q0.size() > 0;
      s1_valid = q1.size() > 0;
      s0_data  = s0_valid ? q0[0][7:0] : 8'($urandom);
      s0_last  = s0_valid ? q0[0][8]   : 1'($urandom);
      s1_data  = s1_valid ? q1[0][7:0] : 8'($urandom);
      s1_last  = s1_valid ? q1[0][8]   : 1'($urandom);
    end
  end

  // Monitor: logs {grant, byte} on every pulse and counts protocol violations
  int n_done = 0, n_ovf = 0, viol = 0, cyc = 0;
  initial begin
    bit         prev_tx = 0, prev_ub = 0, prev_done = 0, prev_busy = 0, prev_grant = 0;
    bit         have_last = 0;
    logic [7:0] prev_byte = 0;
    int         rst_recent = 0, last_pulse = 0, last_epoch = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) rst_recent = 2; else if (rst_recent > 0) rst_recent--;
      if (uart_transmit === 1'b1) begin
        if (ub) viol++;
        if (prev_tx) viol++;
        if (have_last && last_epoch == epoch && (cyc - last_pulse) < bt + 3) viol++;
        last_pulse = cyc; last_epoch = epoch; have_last = 1;
        log_q.push_back({grant, uart_tx_byte});
      end
      if (ub && prev_ub && rst_recent == 0 && uart_tx_byte !== prev_byte) viol++;
      if (frame_done === 1'b1) begin n_done++; if (prev_done) viol++; end
      if (overflow === 1'b1) begin n_ovf++; if (frame_done !== 1'b1) viol++; end
      if ((s0_ready === 1'b1 && (grant !== 1'b0 || !s0_valid)) ||
          (s1_ready === 1'b1 && (grant !== 1'b1 || !s1_valid))) viol++;
      if (prev_busy && busy === 1'b1 && grant !== prev_grant) viol++;
      prev_tx = (uart_transmit === 1'b1); prev_ub = ub; prev_byte = uart_tx_byte;
      prev_done = (frame_done === 1'b1); prev_busy = (busy === 1'b1); prev_grant = grant;
    end
  end

  // Reference model: cut each channel's bytes into frames, alternate on ties
  task automatic model_chunk(input bit ch);
    logic [7:0] c;
    logic [8:0] e;
    int n = 0;
    bit lastb = 0;
    c = {7'b0, ch};
    exp_q.push_back({ch, SYNC});
    exp_q.push_back({ch, c});
    while (!lastb && n < MAXP && (ch ? m1.size() : m0.size()) > 0) begin
      e = ch ? m1.pop_front() : m0.pop_front();
      exp_q.push_back({ch, e[7:0]});
      c = c ^ e[7:0];
      n++;
      lastb = e[8];
    end
    exp_q.push_back({ch, c});
    exp_done++;
    if (!lastb) exp_ovf++;
  endtask

  task automatic model_run();
    bit ch;
    while (m0.size() > 0 || m1.size() > 0) begin
      ch = (m0.size() > 0 && m1.size() > 0) ? rr_m : (m0.size() == 0);
      model_chunk(ch);
      rr_m = !ch;
    end
  endtask

  task automatic add_frame(input bit ch, input int len, input bit to_model);
    logic [8:0] b;
    for (int i = 0; i < len; i++) begin
      b = {(i == len - 1), 8'($urandom)};
      if (ch) q1.push_back(b); else q0.push_back(b);
      if (to_model) begin
        if (ch) m1.push_back(b); else m0.push_back(b);
      end
    end
  endtask

  int log_base, done_base, ovf_base, viol_base;
  task automatic begin_scenario();
    log_base = log_q.size(); done_base = n_done; ovf_base = n_ovf; viol_base = viol;
    exp_q.delete(); exp_done = 0; exp_ovf = 0;
  endtask

  task automatic set_bt(input int v);
    bt = v;
    epoch++;
  endtask

  task automatic wait_idle(output bit ok, input int budget);
    int k = 0, quiet = 0;
    while (quiet < 4 && k < budget) begin
      @(negedge clk);
      k++;
      if (q0.size() == 0 && q1.size() == 0 && busy === 1'b0 && !ub && frame_done === 1'b0)
        quiet++;
      else
        quiet = 0;
    end
    ok = (quiet >= 4);
  endtask

  task automatic do_reset();
    @(posedge clk); #2; rst = 1;
    @(posedge clk); #2; rst = 0;
    rr_m = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant got %b want 0", grant); end
    checks++; if (uart_transmit !== 1'b0) begin errors++; $display("FAIL reset_transmit got %b want 0", uart_transmit); end
    checks++; if (uart_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got %h want 00", uart_tx_byte); end
    checks++; if ({s0_ready, s1_ready, frame_done, overflow} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {s0_ready, s1_ready, frame_done, overflow});
    end
    rst = 0;
    rr_m = 0;
  endtask

  task automatic test_single_frame();
    bit ok;
    set_bt(2170);
    begin_scenario();
    @(posedge clk); #2;
    q0.push_back(9'h011); q0.push_back(9'h122);
    m0.push_back(9'h011); m0.push_back(9'h122);
    model_run();
    wait_idle(ok, 20000);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got busy=%b want idle", busy); end
    checks++; if (log_q.size() - log_base != exp_q.size()) begin
      errors++; $display("FAIL single_count got %0d want %0d", log_q.size() - log_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
      checks++; if (log_q[log_base + i] !== exp_q[i]) begin
        errors++; $display("FAIL single_byte[%0d] got %h want %h", i, log_q[log_base + i], exp_q[i]);
      end
    end
    checks++; if (n_done - done_base != 1) begin errors++; $display("FAIL single_done got %0d want 1", n_done - done_base); end
    checks++; if (viol != viol_base) begin errors++; $display("FAIL single_protocol got %0d want 0", viol - viol_base); end
  endtask

  task automatic test_round_robin();
    bit ok;
    set_bt($urandom_range(1, 6));
    do_reset();
    begin_scenario();
    for (int f = 0; f < 4; f++) add_frame(f[0], $urandom_range(1, 5), 1);
    model_run();
    wait_idle(ok, 5000);
    checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got busy=%b want idle", busy); end
    checks++; if (log_q.size() - log_base != exp_q.size()) begin
      errors++; $display("FAIL rr_count got %0d want %0d", log_q.size() - log_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
      checks++; if (log_q[log_base + i] !== exp_q[i]) begin
        errors++; $display("FAIL rr_byte[%0d] got %h want %h", i, log_q[log_base + i], exp_q[i]);
      end
    end
    checks++; if (n_done - done_base != 4) begin errors++; $display("FAIL rr_done got %0d want 4", n_done - done_base); end
    checks++; if (viol != viol_base) begin errors++; $display("FAIL rr_protocol got %0d want 0", viol - viol_base); end
  endtask

  task automatic test_overflow();
    bit ok;
    set_bt($urandom_range(1, 6));
    begin_scenario();
    @(posedge clk); #2;
    add_frame(1, 70, 1);
    model_run();
    wait_idle(ok, 5000);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got busy=%b want idle", busy); end
    checks++; if (log_q.size() - log_base != exp_q.size()) begin
      errors++; $display("FAIL ovf_count got %0d want %0d", log_q.size() - log_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
      checks++; if (log_q[log_base + i] !== exp_q[i]) begin
        errors++; $display("FAIL ovf_byte[%0d] got %h want %h", i, log_q[log_base + i], exp_q[i]);
      end
    end
    checks++; if (n_ovf - ovf_base != 1) begin errors++; $display("FAIL ovf_pulses got %0d want 1", n_ovf - ovf_base); end
    checks++; if (n_done - done_base != 2) begin errors++; $display("FAIL ovf_done got %0d want 2", n_done - done_base); end
    checks++; if (viol != viol_base) begin errors++; $display("FAIL ovf_protocol got %0d want 0", viol - viol_base); end
  endtask

  task automatic test_stall();
    bit ok;
    int k, n;
    logic [8:0] b[5];
    set_bt($urandom_range(2, 6));
    begin_scenario();
    for (int i = 0; i < 5; i++) begin
      b[i] = {(i == 4), 8'($urandom)};
      m0.push_back(b[i]);
    end
    model_run();
    @(posedge clk); #2;
    q0.push_back(b[0]); q0.push_back(b[1]);
    k = 0;
    while (q0.size() > 0 && k < 2000) begin @(negedge clk); k++; end
    checks++; if (q0.size() != 0) begin errors++; $display("FAIL stall_first_bytes got %0d left want 0", q0.size()); end
    repeat (bt + 10) @(negedge clk);
    n = log_q.size();
    repeat (500) @(negedge clk);
    checks++; if (log_q.size() != n) begin errors++; $display("FAIL stall_gap_pulses got %0d want 0", log_q.size() - n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %b want 1", busy); end
    @(posedge clk); #2;
    for (int i = 2; i < 5; i++) q0.push_back(b[i]);
    wait_idle(ok, 3000);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got busy=%b want idle", busy); end
    checks++; if (log_q.size() - log_base != exp_q.size()) begin
      errors++; $display("FAIL stall_count got %0d want %0d", log_q.size() - log_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
      checks++; if (log_q[log_base + i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_byte[%0d] got %h want %h", i, log_q[log_base + i], exp_q[i]);
      end
    end
    checks++; if (viol != viol_base) begin errors++; $display("FAIL stall_protocol got %0d want 0", viol - viol_base); end
  endtask

  task automatic test_random();
    bit ok;
    int r, nf;
    for (int round = 0; round < 3; round++) begin
      set_bt($urandom_range(1, 8));
      begin_scenario();
      @(posedge clk); #2;
      nf = 0;
      for (int f = 0; f < 4; f++) begin
        if ($urandom_range(0, 3) != 0 || (f == 3 && nf == 0)) begin
          r = $urandom_range(0, 5);
          add_frame(f[0], (r == 0) ? 64 : (r == 1) ? $urandom_range(65, 70) : $urandom_range(1, 20), 1);
          nf++;
        end
      end
      model_run();
      wait_idle(ok, 20000);
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout got busy=%b want idle", busy); end
      checks++; if (log_q.size() - log_base != exp_q.size()) begin
        errors++; $display("FAIL rand_count got %0d want %0d", log_q.size() - log_base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
        checks++; if (log_q[log_base + i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_byte[%0d] got %h want %h", i, log_q[log_base + i], exp_q[i]);
        end
      end
      checks++; if (n_done - done_base != exp_done) begin errors++; $display("FAIL rand_done got %0d want %0d", n_done - done_base, exp_done); end
      checks++; if (n_ovf - ovf_base != exp_ovf) begin errors++; $display("FAIL rand_ovf got %0d want %0d", n_ovf - ovf_base, exp_ovf); end
      checks++; if (viol != viol_base) begin errors++; $display("FAIL rand_protocol got %0d want 0", viol - viol_base); end
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int k;
    set_bt(200);
    begin_scenario();
    @(posedge clk); #2;
    add_frame(0, 10, 0);
    k = 0;
    while (!(log_q.size() - log_base >= 4 && ub) && k < 5000) begin @(negedge clk); k++; end
    checks++; if (!(log_q.size() - log_base >= 4 && ub)) begin
      errors++; $display("FAIL midrst_reach_payload got %0d bytes want >=4", log_q.size() - log_base);
    end
    @(posedge clk); #2;
    rst = 1;
    q0.delete();
    @(posedge clk); #2;
    checks++; if ({busy, grant, uart_transmit, s0_ready, s1_ready, frame_done, overflow} !== 7'b0) begin
      errors++; $display("FAIL midrst_outputs got %b want 0000000",
                         {busy, grant, uart_transmit, s0_ready, s1_ready, frame_done, overflow});
    end
    checks++; if (uart_tx_byte !== 8'h00) begin errors++; $display("FAIL midrst_tx_byte got %h want 00", uart_tx_byte); end
    rst = 0;
    rr_m = 0;
    begin_scenario();
    q1.push_back(9'h177); m1.push_back(9'h177);
    model_run();
    wait_idle(ok, 5000);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout got busy=%b want idle", busy); end
    checks++; if (log_q.size() - log_base != exp_q.size()) begin
      errors++; $display("FAIL midrst_count got %0d want %0d", log_q.size() - log_base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && log_base + i < log_q.size(); i++) begin
      checks++; if (log_q[log_base + i] !== exp_q[i]) begin
        errors++; $display("FAIL midrst_byte[%0d] got %h want %h", i, log_q[log_base + i], exp_q[i]);
      end
    end
    checks++; if (viol != viol_base) begin errors++; $display("FAIL midrst_protocol got %0d want 0", viol - viol_base); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_overflow();
    test_stall();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
